// File: rtl/sensor_scheduler_if.sv
// Host / sensor / decoder bundle for sensor_scheduler.
// master = environment driving frames and strobes, slave = the scheduler.
interface sensor_scheduler_if #(
    parameter int N_SENSORS = 8
);
    logic                       data_received;
    logic [15:0]                data;
    logic [N_SENSORS-1:0]       done_sensors;
    logic [8*N_SENSORS-1:0]     data_sensors;
    logic [6*N_SENSORS-1:0]     response_sensors;
    logic                       done_decoder;
    logic [N_SENSORS-1:0]       en_sensors_o;
    logic [7:0]                 command_sensor_o;
    logic [7:0]                 address_sensor_o;
    logic [7:0]                 data_sensor_o;
    logic [7:0]                 response_sensor_o;
    logic                       en_decoder_o;
    logic                       cmd_drop_o;
    logic [2:0]                 state_o;

    modport master (
        output data_received, data, done_sensors, data_sensors, response_sensors, done_decoder,
        input  en_sensors_o, command_sensor_o, address_sensor_o, data_sensor_o,
               response_sensor_o, en_decoder_o, cmd_drop_o, state_o
    );

    modport slave (
        input  data_received, data, done_sensors, data_sensors, response_sensors, done_decoder,
        output en_sensors_o, command_sensor_o, address_sensor_o, data_sensor_o,
               response_sensor_o, en_decoder_o, cmd_drop_o, state_o
    );
endinterface

// File: rtl/sensor_scheduler.sv
// Serves host read/mask frames and round-robin continuous sensor slots, one transaction at a time.
// Optional macro SCHED_TIMEOUT_EN adds a sensor-response timeout in WAIT_SENSOR.
module sensor_scheduler #(
    parameter int N_SENSORS      = 8,
    parameter int GAP_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input logic               clk,
    input logic               rst,
    sensor_scheduler_if.slave bus
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] ISSUE       = 3'd1;
    localparam logic [2:0] WAIT_SENSOR = 3'd2;
    localparam logic [2:0] DECODE      = 3'd3;
    localparam logic [2:0] GAP         = 3'd4;

    localparam int          N_SLOTS   = 2 * N_SENSORS;
    localparam logic [7:0]  ADDR_BASE = 8'h31;
    localparam logic [7:0]  ADDR_LAST = 8'(32'h31 + N_SENSORS - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 1) : 32'd0;
`ifdef SCHED_TIMEOUT_EN
    localparam logic [31:0] TO_LAST   = (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
    logic [31:0] to_cnt;
`endif

    logic [2:0]                    state;
    logic                          pend_vld;
    logic [15:0]                   pend;
    logic [N_SENSORS-1:0]          temp_mask, umid_mask;
    logic [N_SLOTS-1:0]            slots;
    logic [3:0]                    last_slot, rr_slot, idx;
    logic                          rr_found;
    logic [2:0]                    cur_ch, p_ch;
    logic [7:0]                    cmd_q, addr_q, dat_q, resp_q, p_cmd, p_addr;
    logic                          dec_q, drop_q;
    logic [31:0]                   gap_cnt;
    logic [N_SENSORS-1:0][7:0]     s_dat;
    logic [N_SENSORS-1:0][5:0]     s_resp;
    logic                          addr_ok, cmd_ok, pend_bad, pend_take;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_ch
        assign slots[2*i]   = temp_mask[i];
        assign slots[2*i+1] = umid_mask[i];
        assign s_dat[i]     = bus.data_sensors[8*i +: 8];
        assign s_resp[i]    = bus.response_sensors[6*i +: 6];
    end

    assign p_cmd     = pend[15:8];
    assign p_addr    = pend[7:0];
    assign p_ch      = 3'(p_addr - ADDR_BASE);
    assign addr_ok   = (p_addr >= ADDR_BASE) && (p_addr <= ADDR_LAST);
    assign cmd_ok    = (p_cmd >= 8'h31) && (p_cmd <= 8'h37);
    assign pend_bad  = pend_vld && !(addr_ok && cmd_ok);
    // Bad frames are flushed in any state; good ones wait for IDLE.
    assign pend_take = pend_vld && (pend_bad || state == IDLE);

    always_comb begin
        rr_found = 1'b0;
        rr_slot  = '0;
        idx      = '0;
        for (int k = 1; k <= N_SLOTS; k++) begin
            idx = 4'((int'(last_slot) + k) % N_SLOTS);
            if (!rr_found && slots[idx]) begin
                rr_found = 1'b1;
                rr_slot  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend_vld  <= 1'b0;
            pend      <= '0;
            temp_mask <= '0;
            umid_mask <= '0;
            last_slot <= 4'(N_SLOTS - 1);
            cur_ch    <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            dat_q     <= '0;
            resp_q    <= '0;
            dec_q     <= 1'b0;
            drop_q    <= 1'b0;
            gap_cnt   <= '0;
`ifdef SCHED_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            dec_q  <= 1'b0;
            drop_q <= pend_bad || (bus.data_received && pend_vld && !pend_take);

            if (bus.data_received && (!pend_vld || pend_take)) begin
                pend_vld <= 1'b1;
                pend     <= bus.data;
            end else if (pend_take) begin
                pend_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pend_vld && !pend_bad) begin
                        case (p_cmd)
                            8'h34:   temp_mask[p_ch] <= 1'b1;
                            8'h35:   umid_mask[p_ch] <= 1'b1;
                            8'h36:   temp_mask[p_ch] <= 1'b0;
                            8'h37:   umid_mask[p_ch] <= 1'b0;
                            default: begin
                                addr_q <= p_addr;
                                cmd_q  <= p_cmd;
                                cur_ch <= p_ch;
                                state  <= ISSUE;
                            end
                        endcase
                    end else if (!pend_vld && rr_found) begin
                        cur_ch    <= rr_slot[3:1];
                        addr_q    <= ADDR_BASE + {5'd0, rr_slot[3:1]};
                        cmd_q     <= rr_slot[0] ? 8'h33 : 8'h32;
                        last_slot <= rr_slot;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_SENSOR;
`ifdef SCHED_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_SENSOR: begin
                    if (bus.done_sensors[cur_ch]) begin
                        dat_q  <= s_dat[cur_ch];
                        resp_q <= {2'b00, s_resp[cur_ch]};
                        dec_q  <= 1'b1;
                        state  <= DECODE;
`ifdef SCHED_TIMEOUT_EN
                    end else if (to_cnt >= TO_LAST) begin
                        dat_q  <= 8'h00;
                        resp_q <= 8'hE0;
                        dec_q  <= 1'b1;
                        state  <= DECODE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
`endif
                    end
                end
                DECODE: begin
                    if (bus.done_decoder) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt >= GAP_LAST) state <= IDLE;
                    else gap_cnt <= gap_cnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.en_sensors_o      = (state == ISSUE) ? (N_SENSORS'(1) << cur_ch) : '0;
    assign bus.command_sensor_o  = cmd_q;
    assign bus.address_sensor_o  = addr_q;
    assign bus.data_sensor_o     = dat_q;
    assign bus.response_sensor_o = resp_q;
    assign bus.en_decoder_o      = dec_q;
    assign bus.cmd_drop_o        = drop_q;
    assign bus.state_o           = state;
endmodule

// File: tb/tb_sensor_scheduler.sv
// Scoreboard bench for sensor_scheduler: stimulus feeds a transaction-level model,
// a negedge monitor compares every sensor issue, decoder handoff, drop and gap length.
module tb_sensor_scheduler;
    localparam int N   = 8;
    localparam int GAP = 7;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    sensor_scheduler_if #(.N_SENSORS(N)) bus();

    sensor_scheduler #(.N_SENSORS(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] en; logic [7:0] addr; logic [7:0] cmd; } issue_t;

    int          checks = 0, errors = 0;
    issue_t      host_q[$];
    logic [15:0] dec_q[$];
    bit          tmask[N], umask[N];
    int          rr_last = 2*N - 1;
    int          drop_exp = 0, drop_seen = 0;
    bit          no_resp = 0, fixed = 0;
    logic [7:0]  sd[N];
    logic [5:0]  sr[N];

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign bus.data_sensors[8*i +: 8]     = sd[i];
        assign bus.response_sensors[6*i +: 6] = sr[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---- reference model: masks, round-robin pointer, one-deep host buffer ----
    function automatic bit any_active();
        for (int i = 0; i < N; i++) if (tmask[i] || umask[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int next_slot();
        for (int k = 1; k <= 2*N; k++) begin
            int s = (rr_last + k) % (2*N);
            if ((s % 2 == 0) ? tmask[s/2] : umask[s/2]) return s;
        end
        return -1;
    endfunction

    function automatic void model_frame(input logic [15:0] f);
        logic [7:0] c = f[15:8];
        int ch = int'(f[7:0]) - 'h31;
        if (ch < 0 || ch >= N || c < 8'h31 || c > 8'h37) begin
            drop_exp++;
            return;
        end
        case (c)
            8'h34:   tmask[ch] = 1'b1;
            8'h35:   umask[ch] = 1'b1;
            8'h36:   tmask[ch] = 1'b0;
            8'h37:   umask[ch] = 1'b0;
            default: host_q.push_back({8'(1 << ch), f[7:0], c});
        endcase
    endfunction

    function automatic logic [15:0] rand_frame(input int k);
        logic [7:0] a = 8'(8'h31 + $urandom_range(0, N-1));
        logic [7:0] c;
        if (k < 4) c = 8'(8'h34 + k);
        else if (k < 6 || k == 9) c = 8'(8'h31 + $urandom_range(0, 2));
        else if ($urandom_range(0, 1) == 1) begin
            c = 8'(8'h31 + $urandom_range(0, 6));
            a = ($urandom_range(0, 1) == 1) ? 8'h30 : 8'h39;
        end else c = ($urandom_range(0, 1) == 1) ? 8'h30 : 8'h38;
        return {c, a};
    endfunction

    // ---- monitor ----
    logic [7:0] prev_en = '0;
    logic       prev_dec = 1'b0;
    logic [2:0] prev_state = '0;
    int         gap_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_en = '0; prev_dec = 1'b0; prev_state = '0; gap_run = 0;
        end else begin
            if (bus.en_sensors_o != '0) begin
                issue_t exp;
                int     s;
                check("issue_pulse_width", {56'd0, prev_en}, 64'd0);
                if (host_q.size() > 0) exp = host_q.pop_front();
                else begin
                    s = next_slot();
                    if (s < 0) exp = '0;
                    else begin
                        exp     = {8'(1 << (s/2)), 8'(8'h31 + s/2), (s % 2 == 1) ? 8'h33 : 8'h32};
                        rr_last = s;
                    end
                end
                check("issue", {40'd0, bus.en_sensors_o, bus.address_sensor_o, bus.command_sensor_o}, {40'd0, exp});
            end
            if (bus.en_decoder_o) begin
                check("decoder_pulse_width", {63'd0, prev_dec}, 64'd0);
                if (dec_q.size() == 0) check("decoder_unexpected", 64'd1, 64'd0);
                else check("decode_data", {48'd0, bus.data_sensor_o, bus.response_sensor_o}, {48'd0, dec_q.pop_front()});
            end
            if (bus.cmd_drop_o) drop_seen++;
            if (bus.state_o == 3'd4) gap_run++;
            else begin
                if (prev_state == 3'd4) check("gap_length", 64'(gap_run), 64'(GAP));
                gap_run = 0;
            end
            prev_en = bus.en_sensors_o; prev_dec = bus.en_decoder_o; prev_state = bus.state_o;
        end
    end

    // ---- sensor responder: answers the enabled channel, sometimes after a stray strobe ----
    always begin
        int ch, o;
        @(negedge clk);
        if (!rst && bus.en_sensors_o != '0 && !no_resp) begin
            ch = 0;
            for (int i = 0; i < N; i++) if (bus.en_sensors_o[i]) ch = i;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                o = (ch + 1 + $urandom_range(0, N-2)) % N;
                for (int i = 0; i < N; i++) begin sd[i] = 8'($urandom); sr[i] = 6'($urandom); end
                bus.done_sensors = N'(1) << o;
                @(negedge clk);
            end
            for (int i = 0; i < N; i++) begin sd[i] = 8'($urandom); sr[i] = 6'($urandom); end
            if (fixed) begin sd[ch] = 8'h19; sr[ch] = 6'h09; end
            dec_q.push_back({sd[ch], 2'b00, sr[ch]});
            bus.done_sensors = N'(1) << ch;
            @(negedge clk);
            bus.done_sensors = '0;
        end
    end

    // ---- decoder responder ----
    always begin
        @(negedge clk);
        if (!rst && bus.en_decoder_o) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            bus.done_decoder = 1'b1;
            @(negedge clk);
            bus.done_decoder = 1'b0;
        end
    end

    // ---- stimulus ----
    task automatic wait_state(input logic [2:0] st);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.state_o !== st && n < 2000);
        if (bus.state_o !== st) check("wait_state_timeout", {61'd0, bus.state_o}, {61'd0, st});
    endtask

    task automatic send(input logic [15:0] f, input bit second);
        if (second) drop_exp++;
        else model_frame(f);
        bus.data_received = 1'b1;
        bus.data          = f;
        @(negedge clk);
        bus.data_received = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return {19'd0, bus.en_sensors_o, bus.address_sensor_o, bus.command_sensor_o, bus.data_sensor_o,
                bus.response_sensor_o, bus.en_decoder_o, bus.cmd_drop_o, bus.state_o};
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int kind, st, n;
        bus.data_received = 1'b0; bus.data = '0; bus.done_sensors = '0; bus.done_decoder = 1'b0;
        for (int i = 0; i < N; i++) begin sd[i] = '0; sr[i] = '0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single host read with fixed sensor payload
        fixed = 1;
        send(16'h3132, 0);
        wait_state(3'd4);
        wait_state(3'd0);
        fixed = 0;

        // invalid address: dropped, nothing issued
        send(16'h3139, 0);
        repeat (6) @(negedge clk);
        check("drop_invalid_addr", 64'(drop_seen), 64'(drop_exp));

`ifdef SCHED_TIMEOUT_EN
        no_resp = 1;
        dec_q.push_back(16'h00E0);
        send(16'h3131, 0);
        wait_state(3'd2);
        n = 1;
        while (bus.state_o == 3'd2 && n < 1000) begin @(negedge clk); if (bus.state_o == 3'd2) n++; end
        check("timeout_wait_cycles", 64'(n), 64'(TMO));
        no_resp = 0;
        wait_state(3'd0);
`endif

        // back-to-back mask frames, then alternating continuous slots
        send(16'h3431, 0);
        send(16'h3533, 0);
        repeat (4) wait_state(3'd1);

        // host frame during GAP beats the continuous slot
        wait_state(3'd4);
        send(16'h3338, 0);
        wait_state(3'd1);

        // second frame while buffer full is dropped
        wait_state(3'd2);
        send(16'h3132, 0);
        send(16'h3231, 1);
        wait_state(3'd1);
        check("drop_buffer_full", 64'(drop_seen), 64'(drop_exp));

        for (int it = 0; it < 40 && errors < 10; it++) begin
            if (any_active() || host_q.size() > 0) begin
                wait_state(3'd1);
                st = $urandom_range(2, 4);
                wait_state(3'(st));
            end else begin
                wait_state(3'd0);
                @(negedge clk);
                st = 0;
            end
            kind = $urandom_range(0, 9);
            if (kind != 8) begin
                send(rand_frame(kind), 0);
                if (kind == 9 && st == 2) send(rand_frame($urandom_range(0, 7)), 1);
            end
        end
        wait_state(3'd0);
        repeat (3) @(negedge clk);
        check("drop_random", 64'(drop_seen), 64'(drop_exp));

        // asynchronous reset in DECODE
        if (!any_active()) send(16'h3431, 0);
        wait_state(3'd3);
        #2 rst = 1'b1;
        #1 check("reset_mid_decode", outs(), 64'd0);
        for (int i = 0; i < N; i++) begin tmask[i] = 0; umask[i] = 0; end
        rr_last = 2*N - 1;
        host_q.delete();
        dec_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (100) @(negedge clk);
        check("post_reset_idle", {61'd0, bus.state_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
